// File: rtl/qam_pkg.sv
// Shared 16-QAM constants, sample/product types and Gray level mapping.
// Used by both the modulator and the demodulator.
package qam_pkg;

    localparam int SPS    = 32;
    localparam int PH_W   = $clog2(SPS);
    localparam int ACC_W  = 21;
    localparam int THRESH = 65024;

    localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

    localparam logic [1:0] LVL_M3 = 2'b00;
    localparam logic [1:0] LVL_M1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_P3 = 2'b10;

    typedef logic signed [7:0]  sample_t;
    typedef logic signed [15:0] product_t;

    function automatic logic [1:0] gray_level(input logic neg, input logic outer);
        logic [1:0] lvl;
        case ({neg, outer})
            2'b11:   lvl = LVL_M3;
            2'b10:   lvl = LVL_M1;
            2'b00:   lvl = LVL_P1;
            2'b01:   lvl = LVL_P3;
            default: lvl = LVL_P1;
        endcase
        return lvl;
    endfunction

    // A magnitude exactly on the threshold decides for the outer level.
    function automatic logic [1:0] slice_axis(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] mag;
        logic             neg;
        logic             outer;
        neg = v[ACC_W-1];
        if (neg) begin
            mag = -v;
        end else begin
            mag = v;
        end
        outer = (mag >= THRESH_V);
        return gray_level(neg, outer);
    endfunction

endpackage

// File: rtl/carrier_lut.sv
// Registered cosine/sine carrier table, round(127*cos/sin(2*pi*k/SPS)).
// Same contents as the transmitter's carrier generator.
module carrier_lut
    import qam_pkg::*;
(
    input  logic            Clk,
    input  logic            reset,
    input  logic [PH_W-1:0] phase,
    output sample_t         cos_out,
    output sample_t         sin_out
);

    function automatic sample_t cos_tab(input logic [PH_W-1:0] k);
        sample_t v;
        case (k)
            5'd0:  v =  8'sd127;  5'd1:  v =  8'sd125;  5'd2:  v =  8'sd117;  5'd3:  v =  8'sd106;
            5'd4:  v =  8'sd90;   5'd5:  v =  8'sd71;   5'd6:  v =  8'sd49;   5'd7:  v =  8'sd25;
            5'd8:  v =  8'sd0;    5'd9:  v = -8'sd25;   5'd10: v = -8'sd49;   5'd11: v = -8'sd71;
            5'd12: v = -8'sd90;   5'd13: v = -8'sd106;  5'd14: v = -8'sd117;  5'd15: v = -8'sd125;
            5'd16: v = -8'sd127;  5'd17: v = -8'sd125;  5'd18: v = -8'sd117;  5'd19: v = -8'sd106;
            5'd20: v = -8'sd90;   5'd21: v = -8'sd71;   5'd22: v = -8'sd49;   5'd23: v = -8'sd25;
            5'd24: v =  8'sd0;    5'd25: v =  8'sd25;   5'd26: v =  8'sd49;   5'd27: v =  8'sd71;
            5'd28: v =  8'sd90;   5'd29: v =  8'sd106;  5'd30: v =  8'sd117;  5'd31: v =  8'sd125;
            default: v = 8'sd0;
        endcase
        return v;
    endfunction

    // Table read register; sine is the cosine a quarter period earlier.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cos_out <= 8'sd0;
            sin_out <= 8'sd0;
        end else begin
            cos_out <= cos_tab(phase);
            sin_out <= cos_tab(phase - 5'd8);
        end
    end

endmodule

// File: rtl/qam_demod.sv
// Coherent 16-QAM demodulator: carrier mixing, per-symbol integrate-and-dump,
// and Gray-coded slicing of the I/Q integrals.
module qam_demod
    import qam_pkg::*;
(
    input  logic                    Clk,
    input  logic                    reset,
    input  sample_t                 sample_in,
    input  logic                    sample_valid,
    input  logic                    sym_start,
    output logic [3:0]              sym_out,
    output logic                    sym_valid,
    output logic signed [ACC_W-1:0] i_acc_out,
    output logic signed [ACC_W-1:0] q_acc_out
);

    logic [PH_W-1:0]         ph_r;
    logic [PH_W-1:0]         cur_ph_s;
    logic                    restart_s;
    sample_t                 s1_x_r;
    logic                    s1_v_r;
    logic                    s1_last_r;
    sample_t                 cos_s;
    sample_t                 sin_s;
    product_t                p_i_r;
    product_t                p_q_r;
    logic                    s2_v_r;
    logic                    s2_last_r;
    logic signed [ACC_W-1:0] acc_i_r;
    logic signed [ACC_W-1:0] acc_q_r;
    logic signed [ACC_W-1:0] fin_i_s;
    logic signed [ACC_W-1:0] fin_q_s;
    logic                    dump_s;
    logic [3:0]              sym_next_s;

    // Phase of the incoming sample; a mid-symbol start restarts at phase 0.
    always_comb begin
        cur_ph_s  = ph_r;
        restart_s = 1'b0;
        if (sample_valid && sym_start) begin
            cur_ph_s  = {PH_W{1'b0}};
            restart_s = (ph_r != {PH_W{1'b0}});
        end else begin
            cur_ph_s  = ph_r;
            restart_s = 1'b0;
        end
    end

    // Phase counter advances only on accepted samples.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            ph_r <= {PH_W{1'b0}};
        end else if (sample_valid) begin
            ph_r <= cur_ph_s + 1'b1;
        end
    end

    carrier_lut u_carrier_lut (
        .Clk     (Clk),
        .reset   (reset),
        .phase   (cur_ph_s),
        .cos_out (cos_s),
        .sin_out (sin_s)
    );

    // S1: sample, symbol-end flag and valid, aligned with the LUT read.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s1_x_r    <= 8'sd0;
            s1_v_r    <= 1'b0;
            s1_last_r <= 1'b0;
        end else begin
            s1_x_r    <= sample_in;
            s1_v_r    <= sample_valid;
            s1_last_r <= (cur_ph_s == {PH_W{1'b1}});
        end
    end

    // S2: mixer products; an in-flight entry of an abandoned symbol is dropped.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            p_i_r     <= 16'sd0;
            p_q_r     <= 16'sd0;
            s2_v_r    <= 1'b0;
            s2_last_r <= 1'b0;
        end else begin
            p_i_r     <= product_t'(s1_x_r) * product_t'(cos_s);
            p_q_r     <= product_t'(s1_x_r) * product_t'(sin_s);
            s2_v_r    <= s1_v_r & ~restart_s;
            s2_last_r <= s1_last_r;
        end
    end

    // Running integrals including the product currently in S2, and their decisions.
    always_comb begin
        fin_i_s    = acc_i_r + ACC_W'(p_i_r);
        fin_q_s    = acc_q_r + ACC_W'(p_q_r);
        dump_s     = s2_v_r & s2_last_r;
        sym_next_s = {slice_axis(fin_i_s), slice_axis(fin_q_s)};
    end

    // Integrate-and-dump; a restart also clears any partial integral.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            acc_i_r <= {ACC_W{1'b0}};
            acc_q_r <= {ACC_W{1'b0}};
        end else if (restart_s || dump_s) begin
            acc_i_r <= {ACC_W{1'b0}};
            acc_q_r <= {ACC_W{1'b0}};
        end else if (s2_v_r) begin
            acc_i_r <= fin_i_s;
            acc_q_r <= fin_q_s;
        end
    end

    // Decision register: outputs hold until the next completed symbol.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sym_out   <= 4'd0;
            sym_valid <= 1'b0;
            i_acc_out <= {ACC_W{1'b0}};
            q_acc_out <= {ACC_W{1'b0}};
        end else if (dump_s) begin
            sym_out   <= sym_next_s;
            sym_valid <= 1'b1;
            i_acc_out <= fin_i_s;
            q_acc_out <= fin_q_s;
        end else begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qam_demod.sv
// Self-checking bench for qam_demod: modulator model feeds samples, expected
// decisions and integrals go into a scoreboard and are checked on each pulse.
module tb_qam_demod;
    import qam_pkg::*;

    logic                    Clk = 1'b0;
    logic                    reset;
    sample_t                 sample_in;
    logic                    sample_valid;
    logic                    sym_start;
    logic [3:0]              sym_out;
    logic                    sym_valid;
    logic signed [ACC_W-1:0] i_acc_out;
    logic signed [ACC_W-1:0] q_acc_out;

    qam_demod dut (
        .Clk          (Clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .i_acc_out    (i_acc_out),
        .q_acc_out    (q_acc_out)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] sym;
        int         ei;
        int         eq;
        int         due;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   xbuf[32];
    int   lv[4];
    int   si, sq;

    localparam real W = 2.0 * 3.14159265358979 / 32.0;

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic logic [1:0] gray(input int v);
        case (v)
            -3:      return 2'b00;
            -1:      return 2'b01;
            1:       return 2'b11;
            3:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] slice(input int v);
        int av;
        av = (v < 0) ? -v : v;
        if (v < 0) return gray((av >= 65024) ? -3 : -1);
        return gray((av >= 65024) ? 3 : 1);
    endfunction

    task automatic build_qam(input int i_lvl, input int q_lvl);
        for (int n = 0; n < 32; n++)
            xbuf[n] = rnd(16.0 * (i_lvl * $cos(W * n) + q_lvl * $sin(W * n)));
    endtask

    task automatic model_sums(output int s_i, output int s_q);
        s_i = 0;
        s_q = 0;
        for (int n = 0; n < 32; n++) begin
            s_i += xbuf[n] * rnd(127.0 * $cos(W * n));
            s_q += xbuf[n] * rnd(127.0 * $sin(W * n));
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sym_valid === 1'b1) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_pulse observed sym_out=%b expected no pulse", sym_out);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                assert (sym_out === e.sym) else begin
                    n_err++;
                    $error("FAIL sym_%0d observed %b expected %b", e.tag, sym_out, e.sym);
                end
                n_vec++;
                assert (i_acc_out === ACC_W'(e.ei)) else begin
                    n_err++;
                    $error("FAIL iacc_%0d observed %0d expected %0d", e.tag, i_acc_out, e.ei);
                end
                n_vec++;
                assert (q_acc_out === ACC_W'(e.eq)) else begin
                    n_err++;
                    $error("FAIL qacc_%0d observed %0d expected %0d", e.tag, q_acc_out, e.eq);
                end
                n_vec++;
                assert (cyc === e.due) else begin
                    n_err++;
                    $error("FAIL latency_%0d observed cycle %0d expected cycle %0d", e.tag, cyc, e.due);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        check_out();
    endtask

    task automatic drive(input sample_t x, input logic v, input logic st);
        sample_in    = x;
        sample_valid = v;
        sym_start    = st;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(8'sd0, 1'b0, 1'b0);
    endtask

    task automatic send_block(input logic [3:0] esym, input int ei, input int eq,
                              input int gap, input logic st0, input int tag);
        exp_t e;
        int   g;
        for (int n = 0; n < 32; n++) begin
            g = 0;
            while (gap > 0 && g < 6 && $urandom_range(99) < gap) begin
                drive(sample_t'($urandom_range(255)), 1'b0, 1'($urandom_range(1)));
                g++;
            end
            drive(sample_t'(xbuf[n]), 1'b1, (n == 0) ? st0 : 1'b0);
        end
        e.sym = esym;
        e.ei  = ei;
        e.eq  = eq;
        e.due = cyc + 2;
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        lv           = '{-3, -1, 1, 3};
        reset        = 1'b1;
        sample_in    = 8'sd0;
        sample_valid = 1'b0;
        sym_start    = 1'b0;

        // Reset held with random activity on the inputs.
        for (int k = 0; k < 10; k++)
            drive(sample_t'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        n_vec++;
        assert (sym_out === 4'd0) else begin n_err++; $error("FAIL rst_sym observed %b expected 0000", sym_out); end
        n_vec++;
        assert (sym_valid === 1'b0) else begin n_err++; $error("FAIL rst_valid observed %b expected 0", sym_valid); end
        n_vec++;
        assert (i_acc_out === 21'sd0) else begin n_err++; $error("FAIL rst_iacc observed %0d expected 0", i_acc_out); end
        n_vec++;
        assert (q_acc_out === 21'sd0) else begin n_err++; $error("FAIL rst_qacc observed %0d expected 0", q_acc_out); end
        reset = 1'b0;
        idle(3);

        // Single symbol I=+1, Q=+1 with sym_start at natural phase 0.
        build_qam(1, 1);
        model_sums(si, sq);
        send_block({gray(1), gray(1)}, si, sq, 0, 1'b1, 1);
        idle(6);
        n_vec++;
        assert (sym_out === 4'b1111) else begin n_err++; $error("FAIL hold_sym observed %b expected 1111", sym_out); end

        // All sixteen symbols back to back.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                build_qam(lv[a], lv[b]);
                model_sums(si, sq);
                send_block({gray(lv[a]), gray(lv[b])}, si, sq, 0, 1'b0, 10 + a * 4 + b);
            end
        end
        idle(4);

        // Random gaps in sample_valid, I=-1, Q=-3.
        build_qam(-1, -3);
        model_sums(si, sq);
        send_block(4'b0100, si, sq, 50, 1'b0, 30);
        idle(4);

        // Partial symbol abandoned by sym_start at its 11th sample.
        build_qam(-3, -3);
        for (int n = 0; n < 10; n++) drive(sample_t'(xbuf[n]), 1'b1, 1'b0);
        build_qam(3, 3);
        model_sums(si, sq);
        send_block(4'b1010, si, sq, 0, 1'b1, 40);
        idle(4);

        // Reset mid-symbol, then a full symbol without sym_start.
        build_qam(1, -1);
        for (int n = 0; n < 15; n++) drive(sample_t'(xbuf[n]), 1'b1, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        build_qam(-1, 3);
        model_sums(si, sq);
        send_block({gray(-1), gray(3)}, si, sq, 0, 1'b0, 50);
        idle(4);

        // Threshold edge: I integral exactly 65024 -> outer level.
        xbuf = '{default: 0};
        xbuf[0] = 127; xbuf[16] = -128; xbuf[1] = 127; xbuf[31] = 127;
        xbuf[2] = 5;   xbuf[4] = 2;     xbuf[6] = 1;   xbuf[7] = 3;
        model_sums(si, sq);
        send_block({2'b10, slice(sq)}, 65024, sq, 0, 1'b0, 60);

        // One below the threshold -> inner level.
        xbuf[6] = 2;
        xbuf[7] = 1;
        model_sums(si, sq);
        send_block({2'b11, slice(sq)}, 65023, sq, 0, 1'b0, 61);
        idle(8);

        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL missing_pulses observed %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
